// File: rtl/fp_accum_seq.sv
// Streaming binary32 accumulator. It folds each packet into a running sum
// by driving an external multi-cycle adder over a start/done handshake.
module fp_accum_seq #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_error,
    input  logic             out_ready,
    output logic             add_start,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_sum,
    input  logic             add_done
);
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        GATHER,
        ISSUE,
        WAIT,
        OUT,
        DRAIN
    } state_t;

    state_t           state;
    logic [31:0]      acc;
    logic [31:0]      opnd;
    logic [CNT_W-1:0] count;
    logic [TW-1:0]    timer;
    logic             err;
    logic             last_q;

    // acc and opnd are the adder operands and are held stable for the whole add
    assign add_a     = acc;
    assign add_b     = opnd;
    assign out_data  = acc;
    assign out_count = count;
    assign out_error = err;
    assign in_ready  = !reset && (state == IDLE || state == GATHER || state == DRAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            opnd      <= '0;
            count     <= '0;
            timer     <= '0;
            err       <= 1'b0;
            last_q    <= 1'b0;
            out_valid <= 1'b0;
            add_start <= 1'b0;
        end else begin
            add_start <= 1'b0;
            case (state)
                IDLE: begin
                    // the first word seeds acc directly; no add against +0.0
                    if (in_valid) begin
                        acc    <= in_data;
                        count  <= CNT_W'(1);
                        err    <= 1'b0;
                        last_q <= in_last;
                        if (in_last) begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                        end else begin
                            state <= GATHER;
                        end
                    end
                end
                GATHER: begin
                    if (in_valid) begin
                        opnd      <= in_data;
                        last_q    <= in_last;
                        add_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (add_done) begin
                        acc <= add_sum;
                        if (count != '1)
                            count <= count + CNT_W'(1);
                        if (last_q) begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                        end else begin
                            state <= GATHER;
                        end
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        err       <= 1'b1;
                        state     <= OUT;
                        out_valid <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= (err && !last_q) ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (in_valid && in_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed bench for fp_accum_seq with a behavioural multi-cycle adder whose
// sums come from a small table of hand-computed binary32 additions.
module tb_fp_accum_seq;
    localparam int unsigned TO = 8;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data = '0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, out_error, add_start, add_done;
    logic [31:0]   out_data, add_a, add_b, add_sum;
    logic [CW-1:0] out_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lat = 0;
    bit stale_go = 1'b0;
    logic m_busy = 1'b0;
    int m_rem = 0;
    logic [63:0] st_log[$];

    fp_accum_seq #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
        .out_error(out_error), .out_ready(out_ready),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_done(add_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (add_start === 1'b1) st_log.push_back({add_a, add_b});

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h40400000, 32'h40800000}: return 32'h40E00000;
            {32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            default:                      return 32'h7FC00000;
        endcase
    endfunction

    // adder model: done first visible lat cycles after the add_start cycle; lat==0 never completes
    always @(posedge clk) begin
        if (reset) begin
            m_busy   <= 1'b0;
            add_done <= 1'b0;
            add_sum  <= '0;
        end else if (add_start) begin
            add_done <= 1'b0;
            m_busy   <= (lat != 0);
            m_rem    <= lat - 1;
            add_sum  <= fadd(add_a, add_b);
        end else if (stale_go) begin
            add_done <= 1'b1;
            add_sum  <= 32'hDEADBEEF;
        end else if (m_busy) begin
            if (m_rem <= 1) begin
                add_done <= 1'b1;
                m_busy   <= 1'b0;
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    typedef struct packed {
        int              n;
        logic [3:0][31:0] w;
        int              lat;
        logic [31:0]     exp_data;
        int              exp_count;
        bit              exp_err;
        int              exp_starts;
        logic [31:0]     fa, fb, la, lb;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [31:0] w0, w1, w2, w3, input int l,
                                input logic [31:0] ed, input int ec, input bit ee, input int es,
                                input logic [31:0] fa, fb, la, lb);
        vec_t v;
        v.n = n; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.lat = l;
        v.exp_data = ed; v.exp_count = ec; v.exp_err = ee; v.exp_starts = es;
        v.fa = fa; v.fb = fb; v.la = la; v.lb = lb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_pkt(input vec_t v, input string tag);
        int sent = 0;
        bit got = 1'b0;
        int guard = 0;
        int base;
        int ns;
        base = st_log.size();
        lat = v.lat;
        while ((sent < v.n || !got) && guard < 200) begin
            @(negedge clk);
            guard++;
            out_ready = 1'b0;
            if (out_valid && !got) begin
                chk({tag, ".data"}, 64'(out_data), 64'(v.exp_data));
                chk({tag, ".count"}, 64'(out_count), 64'(v.exp_count));
                chk({tag, ".error"}, 64'(out_error), 64'(v.exp_err));
                out_ready = 1'b1;
                got = 1'b1;
            end
            if (in_ready && sent < v.n) begin
                in_valid = 1'b1;
                in_data  = v.w[sent];
                in_last  = (sent == v.n - 1);
                sent++;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        chk({tag, ".completed"}, 64'(got && sent == v.n), 64'd1);
        ns = st_log.size() - base;
        chk({tag, ".starts"}, 64'(ns), 64'(v.exp_starts));
        if (v.exp_starts > 0 && ns == v.exp_starts) begin
            chk({tag, ".first_ops"}, st_log[base], {v.fa, v.fb});
            chk({tag, ".last_ops"}, st_log[st_log.size() - 1], {v.la, v.lb});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        int base, c0, s_cyc, o_cyc;
        bit leak, stable, ign;
        logic [31:0] d0;
        logic [CW-1:0] k0;

        vecs[0] = mk(1, 32'h40490FDB, 0, 0, 0, 5, 32'h40490FDB, 1, 0, 0, 0, 0, 0, 0);
        vecs[1] = mk(3, 32'h3F800000, 32'h40000000, 32'h40800000, 0, 5, 32'h40E00000, 3, 0, 2,
                     32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        vecs[2] = mk(2, 32'h3F800000, 32'h3F800000, 0, 0, TO, 32'h40000000, 2, 0, 1,
                     32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        vecs[3] = mk(4, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 0,
                     32'h3F800000, 1, 1, 1,
                     32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000);
        vecs[4] = mk(2, 32'h40000000, 32'h40000000, 0, 0, 3, 32'h40800000, 2, 0, 1,
                     32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst.in_ready", 64'(in_ready), 0);
        chk("rst.out_valid", 64'(out_valid), 0);
        chk("rst.out_data", 64'(out_data), 0);
        chk("rst.out_count", 64'(out_count), 0);
        chk("rst.out_error", 64'(out_error), 0);
        chk("rst.add_start", 64'(add_start), 0);
        chk("rst.add_a", 64'(add_a), 0);
        chk("rst.add_b", 64'(add_b), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle.in_ready", 64'(in_ready), 1);

        // single-word packet: result in the very next cycle, no add
        base = st_log.size();
        in_valid = 1'b1; in_data = 32'h40490FDB; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("single.valid_c1", 64'(out_valid), 1);
        chk("single.data", 64'(out_data), 64'h40490FDB);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("single.no_start", 64'(st_log.size() - base), 0);

        for (int i = 0; i < 5; i++) run_pkt(vecs[i], $sformatf("vec%0d", i));

        // timeout timing, then drain of the remaining word
        lat = 0;
        @(negedge clk);
        c0 = cyc;
        in_valid = 1'b1; in_data = 32'h3F800000; in_last = 1'b0;
        @(negedge clk);
        chk("to.gather_ready", 64'(in_ready), 1);
        in_data = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0;
        s_cyc = -1; o_cyc = -1; leak = 1'b0;
        if (add_start) s_cyc = cyc;
        if (in_ready) leak = 1'b1;
        for (int i = 0; i < 40 && o_cyc < 0; i++) begin
            @(negedge clk);
            if (add_start && s_cyc < 0) s_cyc = cyc;
            if (in_ready) leak = 1'b1;
            if (out_valid) o_cyc = cyc;
        end
        chk("to.start_cycle", 64'(s_cyc - c0), 2);
        chk("to.valid_delay", 64'(o_cyc - s_cyc), 64'(TO + 1));
        chk("to.error", 64'(out_error), 1);
        chk("to.count", 64'(out_count), 1);
        chk("to.no_ready", 64'(leak), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("to.drain_ready", 64'(in_ready), 1);
        in_valid = 1'b1; in_data = 32'h40400000; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("to.drain_quiet", 64'(out_valid), 0);
        chk("to.back_idle", 64'(in_ready), 1);

        // output backpressure for five cycles
        in_valid = 1'b1; in_data = 32'h41200000; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        d0 = out_data; k0 = out_count; stable = out_valid;
        for (int i = 0; i < 6; i++) begin
            if (!out_valid || out_data !== d0 || out_count !== k0 || in_ready) stable = 1'b0;
            if (i == 5) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("bp.stable", 64'(stable), 1);
        chk("bp.data", 64'(d0), 64'h41200000);
        chk("bp.released", 64'(out_valid), 0);
        chk("bp.idle_ready", 64'(in_ready), 1);

        // reset while WAITing, followed by a stale done that must be ignored
        lat = 0;
        in_valid = 1'b1; in_data = 32'h3F800000; in_last = 1'b0;
        @(negedge clk);
        in_data = 32'h40000000; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 10 && !add_start; i++) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst.out_valid", 64'(out_valid), 0);
        chk("mid_rst.out_data", 64'(out_data), 0);
        chk("mid_rst.out_count", 64'(out_count), 0);
        chk("mid_rst.add_a", 64'(add_a), 0);
        chk("mid_rst.add_b", 64'(add_b), 0);
        chk("mid_rst.in_ready", 64'(in_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        stale_go = 1'b1;
        @(negedge clk);
        stale_go = 1'b0;
        ign = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid || !in_ready || add_start) ign = 1'b0;
            @(negedge clk);
        end
        chk("mid_rst.stale_ignored", 64'(ign), 1);
        run_pkt(mk(2, 32'h40000000, 32'h40000000, 0, 0, 2, 32'h40800000, 2, 0, 1,
                   32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000), "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
